uart_imem_loader: RTL and testbench



---
 rtl/uart_imem_loader.sv | 158 +++++++++++++++
 tb/tb_uart_imem_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_imem_loader.sv
// UART 8N1 receiver that packs little-endian bytes into 32-bit
// instruction words for the instruction-memory program path.
module uart_imem_loader #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] IMEM_BASE    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        rx,
  input  logic        prog,
  output logic        memcon_prog_ena,
  output logic [31:0] uart_dout,
  output logic        prog_we,
  output logic [31:0] prog_addr,
  output logic [15:0] word_count,
  output logic        frame_err,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;
  logic          prog_q, prog_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   dout_q, dout_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   count_q, count_d;
  logic          ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      prog_q    <= 1'b0;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      idx_q     <= '0;
      dout_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= IMEM_BASE;
      count_q   <= '0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      prog_q    <= prog_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      dout_q    <= dout_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    prog_d    = prog;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    dout_d    = dout_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    count_d   = count_q;
    ferr_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (prog && !rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == MID) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (!rx_s_q) begin
            ferr_d = 1'b1;
          end else if (prog) begin
            dout_d[{idx_q, 3'b000} +: 8] = shift_q;
            idx_d = idx_q + 2'd1;
            we_d  = (idx_q == 2'd3);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (we_q) begin
      addr_d  = addr_q + 32'd4;
      count_d = count_q + 16'd1;
    end

    // leaving program mode drops any partial word and restarts addressing
    if (!prog) begin
      idx_d   = '0;
      addr_d  = IMEM_BASE;
      count_d = '0;
      we_d    = 1'b0;
    end
  end

  assign memcon_prog_ena = prog_q;
  assign uart_dout       = dout_q;
  assign prog_we         = we_q;
  assign prog_addr       = addr_q;
  assign word_count      = count_q;
  assign frame_err       = ferr_q;
  assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_imem_loader.sv
// Randomized bench for uart_imem_loader against a byte-queue
// reference model of word packing and addressing.
module tb_uart_imem_loader;

  localparam int          CPB  = 8;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        rx = 1'b1;
  logic        prog = 1'b0;
  logic        memcon_prog_ena;
  logic [31:0] uart_dout;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [15:0] word_count;
  logic        frame_err;
  logic        busy;

  int npass = 0;
  int ntot  = 0;

  uart_imem_loader #(
    .CLKS_PER_BIT(CPB),
    .IMEM_BASE   (BASE)
  ) dut (
    .clk            (clk),
    .Rst            (Rst),
    .rx             (rx),
    .prog           (prog),
    .memcon_prog_ena(memcon_prog_ena),
    .uart_dout      (uart_dout),
    .prog_we        (prog_we),
    .prog_addr      (prog_addr),
    .word_count     (word_count),
    .frame_err      (frame_err),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  logic [31:0] wr_a [256];
  logic [31:0] wr_d [256];
  int          wr_n = 0;
  int          ferr_cnt = 0;
  int          busy_cnt = 0;
  bit          ferr_long = 0;
  logic        ferr_prev = 1'b0;

  always @(negedge clk) begin
    if (prog_we && wr_n < 256) begin
      wr_a[wr_n] = prog_addr;
      wr_d[wr_n] = uart_dout;
      wr_n = wr_n + 1;
    end
    if (busy) busy_cnt = busy_cnt + 1;
    if (frame_err) begin
      ferr_cnt = ferr_cnt + 1;
      if (ferr_prev) ferr_long = 1;
    end
    ferr_prev = frame_err;
  end

  logic [7:0]  pend [$];
  logic [31:0] exp_a [$];
  logic [31:0] exp_d [$];
  logic [31:0] m_addr;
  logic [15:0] m_count;

  task automatic m_clear();
    pend.delete();
    exp_a.delete();
    exp_d.delete();
    m_addr  = BASE;
    m_count = 0;
  endtask

  task automatic m_byte(input logic [7:0] b);
    pend.push_back(b);
    if (pend.size() == 4) begin
      exp_d.push_back({pend[3], pend[2], pend[1], pend[0]});
      exp_a.push_back(m_addr);
      m_addr  = m_addr + 32'd4;
      m_count = m_count + 16'd1;
      pend.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = good;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_rand(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      send_byte(b, 1'b1);
      m_byte(b);
    end
  endtask

  task automatic check_words(input int s, input string nm);
    ntot++;
    if (wr_n - s !== exp_a.size())
      $display("FAIL %s count: got %0d want %0d", nm, wr_n - s, exp_a.size());
    else npass++;
    for (int i = 0; i < exp_a.size() && s + i < wr_n; i++) begin
      ntot++;
      if (wr_a[s+i] !== exp_a[i] || wr_d[s+i] !== exp_d[i])
        $display("FAIL %s word%0d: got %h@%h want %h@%h", nm, i,
                 wr_d[s+i], wr_a[s+i], exp_d[i], exp_a[i]);
      else npass++;
    end
    ntot++;
    if (prog_addr !== m_addr || word_count !== m_count)
      $display("FAIL %s ctr: got %h/%0d want %h/%0d", nm,
               prog_addr, word_count, m_addr, m_count);
    else npass++;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) @(negedge clk);
    ntot++;
    if ({memcon_prog_ena, uart_dout, prog_we, prog_addr, word_count,
         frame_err, busy} !== {1'b0, 32'h0, 1'b0, BASE, 16'h0, 1'b0, 1'b0})
      $display("FAIL reset: got %b %h %b %h %h %b %b", memcon_prog_ena,
               uart_dout, prog_we, prog_addr, word_count, frame_err, busy);
    else npass++;
    Rst = 1'b0;
    prog = 1'b1;
    m_clear();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    int s = wr_n;
    logic [7:0] bs [4] = '{8'h13, 8'h05, 8'h10, 8'h00};
    exp_a.delete(); exp_d.delete();
    for (int i = 0; i < 4; i++) begin
      send_byte(bs[i], 1'b1);
      m_byte(bs[i]);
    end
    repeat (10) @(negedge clk);
    ntot++;
    if (s < wr_n && wr_d[s] !== 32'h0010_0513)
      $display("FAIL basic_word: got %h want %h", wr_d[s], 32'h0010_0513);
    else if (s >= wr_n)
      $display("FAIL basic_word: got none want %h", 32'h0010_0513);
    else npass++;
    check_words(s, "basic");
  endtask

  task automatic test_back_to_back();
    int s, f0;
    prog = 1'b0;
    repeat (3) @(negedge clk);
    prog = 1'b1;
    m_clear();
    repeat (3) @(negedge clk);
    s = wr_n; f0 = ferr_cnt;
    send_rand(12);
    repeat (10) @(negedge clk);
    check_words(s, "b2b");
    ntot++;
    if (ferr_cnt !== f0)
      $display("FAIL b2b_ferr: got %0d want %0d", ferr_cnt - f0, 0);
    else npass++;
  endtask

  task automatic test_frame_err();
    int s = wr_n;
    int f0 = ferr_cnt;
    exp_a.delete(); exp_d.delete();
    send_byte(8'hAA, 1'b0);
    repeat (20) @(negedge clk);
    ntot++;
    if (ferr_cnt - f0 !== 1 || ferr_long)
      $display("FAIL ferr_pulse: got %0d long=%0d want 1 long=0",
               ferr_cnt - f0, ferr_long);
    else npass++;
    ntot++;
    if (wr_n !== s)
      $display("FAIL ferr_nowrite: got %0d want %0d", wr_n - s, 0);
    else npass++;
    send_rand(4);
    repeat (10) @(negedge clk);
    check_words(s, "ferr");
  endtask

  task automatic test_glitch();
    int s = wr_n;
    int f0 = ferr_cnt;
    int b0 = busy_cnt;
    exp_a.delete(); exp_d.delete();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    ntot++;
    if (busy !== 1'b0 || busy_cnt == b0)
      $display("FAIL glitch_busy: got %b seen=%0d want 0 seen>0",
               busy, busy_cnt - b0);
    else npass++;
    ntot++;
    if (ferr_cnt !== f0 || wr_n !== s)
      $display("FAIL glitch_quiet: got %0d/%0d want 0/0",
               ferr_cnt - f0, wr_n - s);
    else npass++;
    send_rand(4);
    repeat (10) @(negedge clk);
    check_words(s, "glitch");
  endtask

  task automatic test_prog_drop();
    int s;
    send_rand(2);
    prog = 1'b0;
    #1;
    ntot++;
    if (memcon_prog_ena !== 1'b1)
      $display("FAIL lag_fall_early: got %b want %b", memcon_prog_ena, 1'b1);
    else npass++;
    @(negedge clk);
    ntot++;
    if (memcon_prog_ena !== 1'b0)
      $display("FAIL lag_fall: got %b want %b", memcon_prog_ena, 1'b0);
    else npass++;
    repeat (4) @(negedge clk);
    ntot++;
    if (prog_addr !== BASE || word_count !== 16'h0)
      $display("FAIL drop_clear: got %h/%0d want %h/0",
               prog_addr, word_count, BASE);
    else npass++;
    prog = 1'b1;
    #1;
    ntot++;
    if (memcon_prog_ena !== 1'b0)
      $display("FAIL lag_rise_early: got %b want %b", memcon_prog_ena, 1'b0);
    else npass++;
    @(negedge clk);
    ntot++;
    if (memcon_prog_ena !== 1'b1)
      $display("FAIL lag_rise: got %b want %b", memcon_prog_ena, 1'b1);
    else npass++;
    m_clear();
    s = wr_n;
    send_rand(4);
    repeat (10) @(negedge clk);
    check_words(s, "drop");
  endtask

  task automatic test_rst_mid();
    int s, b0;
    logic [7:0] b = 8'($urandom);
    send_rand(2);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    Rst = 1'b1;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    ntot++;
    if ({memcon_prog_ena, uart_dout, prog_we, prog_addr, word_count,
         frame_err, busy} !== {1'b0, 32'h0, 1'b0, BASE, 16'h0, 1'b0, 1'b0})
      $display("FAIL rst_mid: got %b %h %b %h %h %b %b", memcon_prog_ena,
               uart_dout, prog_we, prog_addr, word_count, frame_err, busy);
    else npass++;
    prog = 1'b0;
    m_clear();
    repeat (2) @(negedge clk);
    Rst = 1'b0;
    repeat (4) @(negedge clk);
    s = wr_n; b0 = busy_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'($urandom), 1'b1);
    repeat (10) @(negedge clk);
    ntot++;
    if (busy_cnt !== b0 || wr_n !== s)
      $display("FAIL prog_off_rx: got busy=%0d we=%0d want 0/0",
               busy_cnt - b0, wr_n - s);
    else npass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_prog_drop();
    test_rst_mid();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
